// File: rtl/alu_lockstep_checker.sv
// Lockstep equivalence checker: drives LFSR stimulus to two ALU lanes, compares their
// results after LAT cycles, and reports the mismatch count and the first failing vector.
module alu_lockstep_checker #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned FLAG_W = 5,
    parameter int unsigned LAT    = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       seed,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic [FLAG_W-1:0] flag_mask,
    output logic [WIDTH-1:0]  stim_a,
    output logic [WIDTH-1:0]  stim_b,
    output logic [OP_W-1:0]   stim_op,
    output logic              stim_c,
    output logic              stim_valid,
    input  logic [WIDTH-1:0]  y1,
    input  logic [WIDTH-1:0]  y2,
    input  logic [FLAG_W-1:0] flags1,
    input  logic [FLAG_W-1:0] flags2,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  first_fail_index,
    output logic [WIDTH-1:0]  first_fail_a,
    output logic [WIDTH-1:0]  first_fail_b,
    output logic [OP_W-1:0]   first_fail_op,
    output logic              first_fail_c
);

    localparam int unsigned STIM_W = 2 * WIDTH + OP_W + 1;
    localparam int unsigned DRN_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned DRN_LD = (LAT > 0) ? LAT - 1 : 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [63:0]        lfsr, lfsr_nxt;
    logic [CNT_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   num_q, num_nxt;
    logic [DRN_W-1:0]   drain_cnt, drain_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   rec_idx, rec_idx_nxt;
    logic [STIM_W-1:0]  rec_stim, rec_stim_nxt;
    logic [STIM_W-1:0]  ff_stim, ff_stim_nxt;
    logic [CNT_W-1:0]   ff_idx_nxt;
    logic               stim_valid_nxt, busy_nxt, done_nxt, pass_nxt;
    logic               start_ok, show_ff, mis;

    logic               d_valid;
    logic [CNT_W-1:0]   d_idx;
    logic [STIM_W-1:0]  d_stim;

    assign stim_a  = lfsr[WIDTH-1:0];
    assign stim_b  = lfsr[2*WIDTH-1:WIDTH];
    assign stim_op = lfsr[2*WIDTH+OP_W-1:2*WIDTH];
    assign stim_c  = lfsr[2*WIDTH+OP_W];

    assign first_fail_a  = ff_stim[WIDTH-1:0];
    assign first_fail_b  = ff_stim[2*WIDTH-1:WIDTH];
    assign first_fail_op = ff_stim[2*WIDTH+OP_W-1:2*WIDTH];
    assign first_fail_c  = ff_stim[2*WIDTH+OP_W];

    // Delay line pairs each lane result with the vector that produced it
    generate
        if (LAT == 0) begin : g_nodly
            assign d_valid = stim_valid;
            assign d_idx   = idx;
            assign d_stim  = lfsr[STIM_W-1:0];
        end else begin : g_dly
            logic [LAT-1:0]    v_pipe;
            logic [CNT_W-1:0]  i_pipe [LAT];
            logic [STIM_W-1:0] s_pipe [LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_pipe <= '0;
                    for (int i = 0; i < int'(LAT); i++) begin
                        i_pipe[i] <= '0;
                        s_pipe[i] <= '0;
                    end
                end else begin
                    v_pipe[0] <= stim_valid;
                    i_pipe[0] <= idx;
                    s_pipe[0] <= lfsr[STIM_W-1:0];
                    for (int i = 1; i < int'(LAT); i++) begin
                        v_pipe[i] <= v_pipe[i-1];
                        i_pipe[i] <= i_pipe[i-1];
                        s_pipe[i] <= s_pipe[i-1];
                    end
                end
            end

            assign d_valid = v_pipe[LAT-1];
            assign d_idx   = i_pipe[LAT-1];
            assign d_stim  = s_pipe[LAT-1];
        end
    endgenerate

    assign mis = d_valid && ((y1 != y2) || (((flags1 ^ flags2) & flag_mask) != '0));

    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        idx_nxt      = idx;
        num_nxt      = num_q;
        drain_nxt    = drain_cnt;
        cnt_nxt      = mismatch_count;
        rec_idx_nxt  = rec_idx;
        rec_stim_nxt = rec_stim;
        start_ok     = 1'b0;

        if (state == RUN) begin
            lfsr_nxt = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
        end

        if (mis) begin
            if (mismatch_count == '0) begin
                rec_idx_nxt  = d_idx;
                rec_stim_nxt = d_stim;
            end
            if (mismatch_count != '1) begin
                cnt_nxt = mismatch_count + CNT_W'(1);
            end
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok     = 1'b1;
                    lfsr_nxt     = {~seed, seed};
                    idx_nxt      = '0;
                    num_nxt      = num_vectors;
                    cnt_nxt      = '0;
                    rec_idx_nxt  = '0;
                    rec_stim_nxt = '0;
                    if (num_vectors != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (idx == num_q - CNT_W'(1)) begin
                    drain_nxt = DRN_W'(DRN_LD);
                    if (LAT > 0) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt - DRN_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A zero-length run holds done low for its first DONE cycle so it rises one edge later
        stim_valid_nxt = (state_nxt == RUN);
        busy_nxt       = (state_nxt == RUN) || (state_nxt == DRAIN);
        done_nxt       = (state_nxt == DONE) && !start_ok;
        pass_nxt       = done_nxt && (cnt_nxt == '0);
        show_ff        = done_nxt && (cnt_nxt != '0);
        ff_idx_nxt     = show_ff ? rec_idx_nxt : '0;
        ff_stim_nxt    = show_ff ? rec_stim_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            lfsr             <= '0;
            idx              <= '0;
            num_q            <= '0;
            drain_cnt        <= '0;
            mismatch_count   <= '0;
            rec_idx          <= '0;
            rec_stim         <= '0;
            stim_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            first_fail_index <= '0;
            ff_stim          <= '0;
        end else begin
            state            <= state_nxt;
            lfsr             <= lfsr_nxt;
            idx              <= idx_nxt;
            num_q            <= num_nxt;
            drain_cnt        <= drain_nxt;
            mismatch_count   <= cnt_nxt;
            rec_idx          <= rec_idx_nxt;
            rec_stim         <= rec_stim_nxt;
            stim_valid       <= stim_valid_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            first_fail_index <= ff_idx_nxt;
            ff_stim          <= ff_stim_nxt;
        end
    end

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Bench for alu_lockstep_checker: three builds (LAT=0, LAT=2, CNT_W=4) driven from a
// table of runs plus a mid-run reset/restart sequence.
module tb_alu_lockstep_checker;

    localparam int unsigned W   = 16;
    localparam int unsigned OPW = 8;
    localparam int unsigned FW  = 5;

    typedef struct {
        int          sel;
        logic [31:0] seed;
        int          n;
        logic [1:0]  mode;
        logic [4:0]  mask;
        int          poke;
        int          exp_cnt;
        int          ffi;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] num = '0;
    logic [4:0]  mask = 5'h1F;
    logic [1:0]  mode = '0;
    int          sel = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // per-instance wiring
    logic [W-1:0]   a0, b0, a1, b1, a2, b2, y1_0, y2_0, y1_1, y2_1, y1_2, y2_2;
    logic [OPW-1:0] op0, op1, op2;
    logic           c0, c1, c2, v0, v1, v2, bz0, bz1, bz2, dn0, dn1, dn2, ps0, ps1, ps2;
    logic [FW-1:0]  f1_0, f2_0, f1_1, f2_1, f1_2, f2_2;
    logic [15:0]    cnt0, cnt1, ffi0, ffi1;
    logic [3:0]     cnt2, ffi2;
    logic [W-1:0]   ffa0, ffb0, ffa1, ffb1, ffa2, ffb2;
    logic [OPW-1:0] ffo0, ffo1, ffo2;
    logic           ffc0, ffc1, ffc2;
    logic           st0, st1, st2;

    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);

    alu_lockstep_checker #(.WIDTH(W), .OP_W(OPW), .FLAG_W(FW), .LAT(0), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(st0), .seed(seed), .num_vectors(num), .flag_mask(mask),
        .stim_a(a0), .stim_b(b0), .stim_op(op0), .stim_c(c0), .stim_valid(v0),
        .y1(y1_0), .y2(y2_0), .flags1(f1_0), .flags2(f2_0),
        .busy(bz0), .done(dn0), .pass(ps0), .mismatch_count(cnt0), .first_fail_index(ffi0),
        .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_op(ffo0), .first_fail_c(ffc0));

    alu_lockstep_checker #(.WIDTH(W), .OP_W(OPW), .FLAG_W(FW), .LAT(2), .CNT_W(16)) u_lat (
        .clk(clk), .reset(reset), .start(st1), .seed(seed), .num_vectors(num), .flag_mask(mask),
        .stim_a(a1), .stim_b(b1), .stim_op(op1), .stim_c(c1), .stim_valid(v1),
        .y1(y1_1), .y2(y2_1), .flags1(f1_1), .flags2(f2_1),
        .busy(bz1), .done(dn1), .pass(ps1), .mismatch_count(cnt1), .first_fail_index(ffi1),
        .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_op(ffo1), .first_fail_c(ffc1));

    alu_lockstep_checker #(.WIDTH(W), .OP_W(OPW), .FLAG_W(FW), .LAT(0), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .start(st2), .seed(seed), .num_vectors(num[3:0]), .flag_mask(mask),
        .stim_a(a2), .stim_b(b2), .stim_op(op2), .stim_c(c2), .stim_valid(v2),
        .y1(y1_2), .y2(y2_2), .flags1(f1_2), .flags2(f2_2),
        .busy(bz2), .done(dn2), .pass(ps2), .mismatch_count(cnt2), .first_fail_index(ffi2),
        .first_fail_a(ffa2), .first_fail_b(ffb2), .first_fail_op(ffo2), .first_fail_c(ffc2));

    function automatic logic [W-1:0] alu_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op, input logic c);
        return op[0] ? (a ^ b) : (a + b + 16'(c));
    endfunction

    function automatic logic [FW-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + 17'(c);
        return {s[W], a < b, ^s[W-1:0], s[W-1:0] == '0, s[W-1]};
    endfunction

    function automatic logic [63:0] step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // lane models: lane 0 by mode, lane 2 always wrong result
    always_comb begin
        y1_0 = alu_y(a0, b0, op0, c0);
        f1_0 = alu_f(a0, b0, c0);
        y2_0 = (mode == 2'd1) ? (y1_0 ^ 16'h0001) : y1_0;
        f2_0 = (mode == 2'd2) ? (f1_0 ^ 5'b00100) : f1_0;
        y1_2 = alu_y(a2, b2, op2, c2);
        f1_2 = alu_f(a2, b2, c2);
        y2_2 = y1_2 ^ 16'h0001;
        f2_2 = f1_2;
    end

    // two-stage lanes for the LAT=2 build; lane 2 corrupts only vector 7
    logic [15:0]   lidx = '0;
    logic [W-1:0]  p1y = '0, p2y = '0;
    logic [FW-1:0] p1f = '0, p2f = '0;
    logic          p1b = 1'b0, p2b = 1'b0;
    always @(posedge clk) begin
        lidx <= v1 ? lidx + 16'd1 : 16'd0;
        p1y  <= alu_y(a1, b1, op1, c1);
        p1f  <= alu_f(a1, b1, c1);
        p1b  <= v1 && (lidx == 16'd7);
        p2y  <= p1y;
        p2f  <= p1f;
        p2b  <= p1b;
    end
    assign y1_1 = p2y;
    assign f1_1 = p2f;
    assign y2_1 = p2b ? (p2y ^ 16'h0001) : p2y;
    assign f2_1 = p2f;

    // view of the selected instance
    logic [W-1:0]   o_a, o_b, o_ffa, o_ffb;
    logic [OPW-1:0] o_op, o_ffo;
    logic           o_c, o_v, o_busy, o_done, o_pass, o_ffc;
    logic [15:0]    o_cnt, o_ffi;
    always_comb begin
        case (sel)
            1: begin
                o_a = a1; o_b = b1; o_op = op1; o_c = c1; o_v = v1; o_busy = bz1;
                o_done = dn1; o_pass = ps1; o_cnt = cnt1; o_ffi = ffi1;
                o_ffa = ffa1; o_ffb = ffb1; o_ffo = ffo1; o_ffc = ffc1;
            end
            2: begin
                o_a = a2; o_b = b2; o_op = op2; o_c = c2; o_v = v2; o_busy = bz2;
                o_done = dn2; o_pass = ps2; o_cnt = {12'd0, cnt2}; o_ffi = {12'd0, ffi2};
                o_ffa = ffa2; o_ffb = ffb2; o_ffo = ffo2; o_ffc = ffc2;
            end
            default: begin
                o_a = a0; o_b = b0; o_op = op0; o_c = c0; o_v = v0; o_busy = bz0;
                o_done = dn0; o_pass = ps0; o_cnt = cnt0; o_ffi = ffi0;
                o_ffa = ffa0; o_ffb = ffb0; o_ffo = ffo0; o_ffc = ffc0;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d)", name, act, exp, sel);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stim"}, 64'({o_c, o_op, o_b, o_a}), 64'd0);
        check({tag, "_status"}, 64'({o_v, o_busy, o_done, o_pass}), 64'd0);
        check({tag, "_cnt"}, 64'(o_cnt), 64'd0);
        check({tag, "_ff"}, 64'({o_ffi, o_ffc, o_ffo, o_ffb, o_ffa}), 64'd0);
    endtask

    task automatic run_row(input row_t r);
        logic [63:0] s;
        logic [40:0] cap;
        int lat, edges, vcount, busy_n, seq_bad, exp_done, exp_busy;
        lat  = (r.sel == 1) ? 2 : 0;
        sel  = r.sel;
        mode = r.mode;
        mask = r.mask;
        seed = r.seed;
        num  = 16'(r.n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = {~r.seed, r.seed};
        cap = '0;
        edges = 0; vcount = 0; busy_n = 0; seq_bad = 0;
        if (r.n > 0) check("first_vec", 64'({o_b, o_a}), 64'(r.seed));
        while (o_done !== 1'b1 && edges < r.n + lat + 10) begin
            if (o_v === 1'b1) begin
                if ({o_c, o_op, o_b, o_a} !== s[40:0]) seq_bad++;
                if (vcount == r.ffi) cap = s[40:0];
                vcount++;
                s = step(s);
            end
            if (o_busy === 1'b1) busy_n++;
            if (r.poke >= 0 && edges == r.poke) begin
                seed  = 32'hFFFF_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        seed  = r.seed;
        exp_done = (r.n == 0) ? 1 : r.n + lat;
        exp_busy = (r.n == 0) ? 0 : r.n + lat;
        check("done_edge", 64'(edges), 64'(exp_done));
        check("valid_cycles", 64'(vcount), 64'(r.n));
        check("busy_cycles", 64'(busy_n), 64'(exp_busy));
        check("stim_seq", 64'(seq_bad), 64'd0);
        check("mismatch_count", 64'(o_cnt), 64'(r.exp_cnt));
        check("pass", 64'(o_pass), 64'(r.exp_cnt == 0));
        check("ff_index", 64'(o_ffi), (r.exp_cnt > 0) ? 64'(r.ffi) : 64'd0);
        check("ff_stim", 64'({o_ffc, o_ffo, o_ffb, o_ffa}), (r.exp_cnt > 0) ? 64'(cap) : 64'd0);
        @(posedge clk);
        #1;
        check("done_hold", 64'({o_done, o_cnt}), 64'({1'b1, 16'(r.exp_cnt)}));
    endtask

    row_t rows [9];
    logic [63:0] ms;
    int sb;

    initial begin
        rows[0] = '{0, 32'h0000_0001, 1000, 2'd0, 5'h1F, -1, 0, 0};
        rows[1] = '{0, 32'hDEAD_BEEF, 10, 2'd1, 5'h1F, -1, 10, 0};
        rows[2] = '{0, 32'h0000_0005, 50, 2'd2, 5'h1B, -1, 0, 0};
        rows[3] = '{0, 32'h0000_0005, 50, 2'd2, 5'h1F, -1, 50, 0};
        rows[4] = '{0, 32'h0000_0007, 0, 2'd0, 5'h1F, -1, 0, 0};
        rows[5] = '{1, 32'h1234_5678, 20, 2'd0, 5'h1F, -1, 1, 7};
        rows[6] = '{2, 32'h0000_0003, 15, 2'd0, 5'h1F, -1, 15, 0};
        rows[7] = '{0, 32'h0000_002A, 30, 2'd0, 5'h1F, 3, 0, 0};
        rows[8] = '{0, 32'h0000_0007, 3, 2'd1, 5'h1F, -1, 3, 0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check_zero("reset");
        end

        for (int i = 0; i < 9; i++) run_row(rows[i]);

        // reset during vector 5, then restart with the same seed
        sel = 0; mode = 2'd1; mask = 5'h1F; seed = 32'd9; num = 16'd20;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ms = {~32'd9, 32'd9};
        sb = 0;
        for (int k = 0; k < 5; k++) begin
            if ({o_c, o_op, o_b, o_a} !== ms[40:0] || o_v !== 1'b1) sb++;
            ms = step(ms);
            @(posedge clk);
            #1;
        end
        check("pre_reset_seq", 64'(sb), 64'd0);
        check("pre_reset_cnt", 64'(o_cnt), 64'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("mid_reset");
        run_row('{0, 32'd9, 20, 2'd1, 5'h1F, -1, 20, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_checker.md
# alu_lockstep_checker

Self-running lockstep equivalence checker for two implementations of the same ALU, such as a behavioural model and its synthesized netlist. It generates a reproducible pseudo-random stimulus stream from a seed and drives identical stimulus to both lanes. It compares results and flags after a parametrised pipeline latency, then reports the mismatch count and the first failing vector. It is the sequential, width-generic successor to our purely combinational equivalence wrapper, and sits in the test harness between the two ALU instances and the bench or status logic.

## Interface
Parameters:
- WIDTH, 16, operand/result width; constraint 2*WIDTH+OP_W+1 ≤ 64
- OP_W, 8, opcode width
- FLAG_W, 5, flag vector width (bit order C,L,F,Z,N at 4..0 for the default ALU)
- LAT, 0, DUT latency in cycles from stimulus to result (0 = combinational)
- CNT_W, 16, width of vector count, index and mismatch counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- seed  in  32  LFSR seed, sampled with start
- num_vectors  in  CNT_W  vectors to issue, sampled with start
- flag_mask  in  FLAG_W  1 = compare that flag bit; held stable during a run
- stim_a, stim_b  out  WIDTH  operands to both DUTs
- stim_op  out  OP_W  opcode to both DUTs
- stim_c  out  1  carry-in to both DUTs
- stim_valid  out  1  stimulus is a counted vector this cycle
- y1, y2  in  WIDTH  lane 1 / lane 2 result
- flags1, flags2  in  FLAG_W  lane 1 / lane 2 flags
- busy  out  1  RUN or DRAIN
- done  out  1  DONE state; results final
- pass  out  1  done and mismatch_count == 0
- mismatch_count  out  CNT_W  saturating mismatch counter
- first_fail_index  out  CNT_W  index of the first mismatching vector
- first_fail_a, first_fail_b  out  WIDTH  its operands
- first_fail_op  out  OP_W  its opcode
- first_fail_c  out  1  its carry-in

## Operation
- **LFSR:** 64-bit Fibonacci LFSR, polynomial x^64+x^63+x^61+x^60+1. Shift left; new bit 0 = s[63]^s[62]^s[60]^s[59].
- **Seeding:** on start, load {~seed, seed}. The state is therefore never all-zero.
- **Stepping:** the LFSR advances one step per cycle in RUN only.
- **Stimulus slices:** the stim outputs are slices of the state register.
  - stim_a = s[WIDTH-1:0]
  - stim_b = s[2W-1:W]
  - stim_op = s[2W+OP_W-1:2W]
  - stim_c = s[2W+OP_W]
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - start with num_vectors > 0 goes to RUN.
  - start with num_vectors == 0 goes to DONE.
- **Entering a run:** clears the counters and the first-fail record.
- **RUN:**
  - stim_valid=1 and one vector is issued per cycle.
  - After num_vectors are issued, go to DRAIN if LAT>0, else DONE.
- **DRAIN:** stim_valid=0. Stay LAT cycles, then go to DONE.
- **DONE:** hold all results. start restarts exactly as from IDLE.
- **start while busy:** ignored.
- **Delay line:** a LAT-deep line carries valid, index and stimulus, so each DUT result is paired with the vector that produced it.
- **Mismatch condition:** (y1 != y2) or ((flags1 ^ flags2) & flag_mask) != 0, for a delayed-valid vector.
- **On mismatch:**
  - mismatch_count increments, saturating at all-ones.
  - If it is the first mismatch of the run, latch index and stimulus into first_fail_*.
- **Reset:** every register clears.
  - State IDLE, LFSR 0, all outputs 0.
  - stim_* = 0, busy = done = pass = 0.
  - Reset mid-run abandons the run with no partial results retained.

## Timing
- start is sampled at edge E0. Vector k is presented in the cycle after edge E(k), for k = 0..N-1.
- The result of vector k is compared at edge E(k+1+LAT). mismatch_count is updated at that edge.
- done and pass rise at edge E(N+LAT). The final compare completes at the same edge, so counts are final whenever done=1.
- With N=0, done rises at edge E1.
- first_fail_* is valid when done=1 and mismatch_count>0. Otherwise it reads 0.
- Same seed and N give a bit-identical stim sequence on every run.

## Test plan
- **Identical lanes, clean run:** lanes tied together (y2=y1, flags2=flags1), LAT=0, seed=1, N=1000.
  - Expect busy for 1000 cycles, done at E1000, pass=1, mismatch_count=0.
  - Expect the first vector stim_a=16'h0001 and stim_b=16'h0000.
- **Always-mismatch result:** y2 = y1 ^ 16'h0001, N=10.
  - Expect mismatch_count=10 and first_fail_index=0.
  - Expect first_fail_a/b/op/c to equal vector 0's stimulus.
- **Flag masking:** flags2 = flags1 ^ 5'b00100, N=50.
  - flag_mask=5'b11011: expect pass=1.
  - flag_mask=5'b11111: expect mismatch_count=50.
- **Zero vectors:** N=0. Expect stim_valid never 1, done at E1, pass=1.
- **Latency and saturation:** LAT=2 build; bench lanes register twice; lane 2 corrupts only vector 7; N=20.
  - Expect mismatch_count=1, first_fail_index=7, done at E22.
  - CNT_W=4 build with all vectors failing: expect the count to saturate at 15.
- **Reset and restart:** assert reset during vector 5.
  - Expect next cycle all outputs 0 and state IDLE.
  - Restart with the same seed: expect the stim sequence to match the first run exactly; start pulses during RUN are ignored.
